// File: rtl/twdl_param_seq_if.sv
// ---------------------------------------------------------------------------
// twdl_param_seq_if
// Bundle between the FFT stage controller/datapath and the twiddle parameter
// sequencer.
//   master : drives start, cfg_* and vec_val; observes the twiddle set
//   slave  : the sequencer; receives requests, returns ready/err and the
//            per-vector twiddle control set
// Signals:
//   start, cfg_demontr, cfg_num_len, cfg_frame_len, cfg_inverse, vec_val
//   ready, err, twdl_val, twdl_sop, twdl_numrtr_1, twdl_demontr,
//   twdl_quotient, twdl_remainder, inverse, frame_done
// ---------------------------------------------------------------------------
interface twdl_param_seq_if #(
    parameter int wNum = 12,
    parameter int wQuo = 20
);
    logic            start;
    logic [wNum-1:0] cfg_demontr;
    logic [wNum-1:0] cfg_num_len;
    logic [15:0]     cfg_frame_len;
    logic            cfg_inverse;
    logic            vec_val;

    logic            ready;
    logic            err;
    logic            twdl_val;
    logic            twdl_sop;
    logic [wNum-1:0] twdl_numrtr_1;
    logic [wNum-1:0] twdl_demontr;
    logic [wQuo-1:0] twdl_quotient;
    logic [wNum-1:0] twdl_remainder;
    logic            inverse;
    logic            frame_done;

    modport master (
        output start, cfg_demontr, cfg_num_len, cfg_frame_len, cfg_inverse, vec_val,
        input  ready, err, twdl_val, twdl_sop, twdl_numrtr_1, twdl_demontr,
               twdl_quotient, twdl_remainder, inverse, frame_done
    );

    modport slave (
        input  start, cfg_demontr, cfg_num_len, cfg_frame_len, cfg_inverse, vec_val,
        output ready, err, twdl_val, twdl_sop, twdl_numrtr_1, twdl_demontr,
               twdl_quotient, twdl_remainder, inverse, frame_done
    );
endinterface

// File: rtl/twdl_param_seq.sv
// ---------------------------------------------------------------------------
// twdl_param_seq
// Twiddle control-set generator for the CTA twiddle multiplier of the
// mixed-radix FFT. On a valid start it divides 2^wQuo by the stage
// denominator D (restoring, one quotient bit per cycle) to get Q1/R1, then on
// every vector request emits n, floor(n*2^wQuo/D) and (n*2^wQuo) mod D,
// stepping n by one with an incremental quotient/remainder update.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : twdl_param_seq_if.slave (start/cfg_*/vec_val in; ready, err,
//            twdl_* set, inverse, frame_done out)
// ---------------------------------------------------------------------------
module twdl_param_seq #(
    parameter int wNum = 12,
    parameter int wQuo = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    twdl_param_seq_if.slave bus
);
    localparam int wFrm = 16;
    localparam int wQ1  = wQuo + 1;
    localparam int wCnt = $clog2(wQ1 + 1);

    localparam logic [wCnt-1:0] DIV_LAST = wCnt'(wQ1 - 1);
    localparam logic [wCnt-1:0] ONE_C    = wCnt'(1);
    localparam logic [wNum-1:0] ONE_N    = wNum'(1);
    localparam logic [wQuo-1:0] ONE_Q    = wQuo'(1);
    localparam logic [wFrm-1:0] ONE_F    = wFrm'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // request decode
    logic cfg_ok;
    logic start_go, start_bad;
    logic vec_go, vec_bad;

    // FSM outputs
    logic ready_c;
    logic div_en;
    logic div_last;

    // latched configuration
    logic [wNum-1:0] dnm;
    logic [wNum-1:0] len_m1;
    logic [wFrm-1:0] frm_m1;
    logic            inv;

    // divider state; after DIV completes div_quo = Q1, div_rem = R1
    logic [wCnt-1:0] div_cnt;
    logic [wNum-1:0] div_rem;
    logic [wQ1-1:0]  div_quo;
    logic [wNum:0]   div_rem_sh;
    logic [wNum:0]   div_diff;
    logic            div_qbit;
    logic [wNum-1:0] div_rem_nx;

    // per-vector accumulators
    logic [wNum-1:0] n_acc;
    logic [wQuo-1:0] q_acc;
    logic [wNum-1:0] r_acc;
    logic [wFrm-1:0] frm_cnt;
    logic [wNum:0]   r_sum;
    logic [wNum:0]   r_diff;
    logic            r_wrap;
    logic [wQuo-1:0] q_sum;
    logic            n_last;

    // registered outputs
    logic            val_p1;
    logic            sop_p1;
    logic            done_p1;
    logic [wNum-1:0] numrtr_p1;
    logic [wQuo-1:0] quo_p1;
    logic [wNum-1:0] rem_p1;
    logic            err_q;

    always_comb begin
        cfg_ok    = (bus.cfg_demontr != '0) && (bus.cfg_num_len != '0) &&
                    (bus.cfg_num_len <= bus.cfg_demontr) && (bus.cfg_frame_len != '0);
        start_go  = bus.start && cfg_ok;
        start_bad = bus.start && !cfg_ok;
        // start always wins over a coincident vector request
        vec_go    = bus.vec_val && !bus.start && (state == RUN);
        vec_bad   = bus.vec_val && !bus.start && (state != RUN);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        div_last  = (state == DIV) && (div_cnt == DIV_LAST);
        if (start_go) begin
            state_nxt = DIV;
        end else if (start_bad) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                DIV:     if (div_last) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_c = (state == RUN);
        div_en  = (state == DIV);
    end

    // Restoring step: the dividend 2^wQuo is a single 1 followed by zeros, so
    // the bit shifted in is 1 only on the first iteration.
    always_comb begin
        div_rem_sh = {div_rem, (div_cnt == '0)};
        div_diff   = div_rem_sh - {1'b0, dnm};
        div_qbit   = (div_rem_sh >= {1'b0, dnm});
        div_rem_nx = div_qbit ? div_diff[wNum-1:0] : div_rem_sh[wNum-1:0];
    end

    // Incremental n*2^wQuo/D update. r and R1 are both below D, so r_sum
    // exceeds D by less than D and one conditional subtract suffices.
    always_comb begin
        r_sum  = {1'b0, r_acc} + {1'b0, div_rem};
        r_diff = r_sum - {1'b0, dnm};
        r_wrap = (r_sum >= {1'b0, dnm});
        q_sum  = q_acc + div_quo[wQuo-1:0];
        n_last = (n_acc == len_m1);
    end

    // ---------------- stage p0 -> p1: config, divider, accumulators, outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dnm       <= '0;
            len_m1    <= '0;
            frm_m1    <= '0;
            inv       <= 1'b0;
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            n_acc     <= '0;
            q_acc     <= '0;
            r_acc     <= '0;
            frm_cnt   <= '0;
            val_p1    <= 1'b0;
            sop_p1    <= 1'b0;
            done_p1   <= 1'b0;
            numrtr_p1 <= '0;
            quo_p1    <= '0;
            rem_p1    <= '0;
            err_q     <= 1'b0;
        end else begin
            val_p1  <= vec_go;
            sop_p1  <= vec_go && (frm_cnt == '0);
            done_p1 <= vec_go && (frm_cnt == frm_m1);

            if (start_go) begin
                err_q <= 1'b0;
            end else if (start_bad || vec_bad) begin
                err_q <= 1'b1;
            end

            if (start_go) begin
                dnm     <= bus.cfg_demontr;
                len_m1  <= bus.cfg_num_len - ONE_N;
                frm_m1  <= bus.cfg_frame_len - ONE_F;
                inv     <= bus.cfg_inverse;
                div_cnt <= '0;
                div_rem <= '0;
                div_quo <= '0;
                n_acc   <= '0;
                q_acc   <= '0;
                r_acc   <= '0;
                frm_cnt <= '0;
            end else begin
                if (div_en) begin
                    div_cnt <= div_cnt + ONE_C;
                    div_rem <= div_rem_nx;
                    div_quo <= {div_quo[wQ1-2:0], div_qbit};
                end
                if (vec_go) begin
                    numrtr_p1 <= n_acc;
                    quo_p1    <= q_acc;
                    rem_p1    <= r_acc;
                    // n = L-1 wraps to 0; with L=1 this also keeps Q1=2^wQuo
                    // (D=1) from ever being accumulated
                    if (n_last) begin
                        n_acc <= '0;
                        q_acc <= '0;
                        r_acc <= '0;
                    end else begin
                        n_acc <= n_acc + ONE_N;
                        if (r_wrap) begin
                            r_acc <= r_diff[wNum-1:0];
                            q_acc <= q_sum + ONE_Q;
                        end else begin
                            r_acc <= r_sum[wNum-1:0];
                            q_acc <= q_sum;
                        end
                    end
                    frm_cnt <= (frm_cnt == frm_m1) ? '0 : frm_cnt + ONE_F;
                end
            end
        end
    end

    assign bus.ready          = ready_c;
    assign bus.err            = err_q;
    assign bus.twdl_val       = val_p1;
    assign bus.twdl_sop       = sop_p1;
    assign bus.frame_done     = done_p1;
    assign bus.twdl_numrtr_1  = numrtr_p1;
    assign bus.twdl_quotient  = quo_p1;
    assign bus.twdl_remainder = rem_p1;
    assign bus.twdl_demontr   = dnm;
    assign bus.inverse        = inv;
endmodule

// File: tb/tb_twdl_param_seq.sv
// ---------------------------------------------------------------------------
// tb_twdl_param_seq
// Directed bench for twdl_param_seq. Stimulus pushes the hand-computed twiddle
// set for every requested vector into a scoreboard queue; an independent
// monitor pops and compares whenever twdl_val is seen.
// ---------------------------------------------------------------------------
module tb_twdl_param_seq;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    twdl_param_seq_if bus_if ();

    twdl_param_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct packed {
        logic [11:0] n;
        logic [19:0] q;
        logic [11:0] r;
        logic        sop;
        logic        fd;
        logic        inv;
        logic [11:0] dmn;
    } exp_t;

    exp_t sb[$];
    exp_t mon_act;
    exp_t mon_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    // hand-computed floor(n*2^20/D) / (n*2^20 mod D) tables
    int q12[4] = '{0, 87381, 174762, 262144};
    int r12[4] = '{0, 4, 8, 0};
    int q5[5]  = '{0, 209715, 419430, 629145, 838860};
    int r5[5]  = '{0, 1, 2, 3, 4};
    int q3[3]  = '{0, 349525, 699050};
    int r3[3]  = '{0, 1, 2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_if.twdl_val === 1'b1) begin
            mon_act = '{n: bus_if.twdl_numrtr_1, q: bus_if.twdl_quotient,
                        r: bus_if.twdl_remainder, sop: bus_if.twdl_sop,
                        fd: bus_if.frame_done, inv: bus_if.inverse,
                        dmn: bus_if.twdl_demontr};
            if (sb.size() == 0) begin
                chk("unexpected_twdl_val", 64'(1), 64'(0));
            end else begin
                mon_exp = sb.pop_front();
                chk("twdl_set", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({bus_if.ready, bus_if.err, bus_if.twdl_val, bus_if.twdl_sop,
                    bus_if.frame_done, bus_if.inverse, bus_if.twdl_numrtr_1,
                    bus_if.twdl_demontr, bus_if.twdl_quotient, bus_if.twdl_remainder});
    endfunction

    task automatic do_start(input logic [11:0] d, input logic [11:0] l,
                            input logic [15:0] f, input logic inv);
        @(negedge clk);
        bus_if.start         = 1'b1;
        bus_if.cfg_demontr   = d;
        bus_if.cfg_num_len   = l;
        bus_if.cfg_frame_len = f;
        bus_if.cfg_inverse   = inv;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    // Called at the negedge right after the start edge; returns the number of
    // further clock edges until ready is seen high.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus_if.ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (bus_if.ready !== 1'b1) chk("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int   cyc;
        exp_t e;

        rst_n                = 1'b0;
        bus_if.start         = 1'b0;
        bus_if.cfg_demontr   = '0;
        bus_if.cfg_num_len   = '0;
        bus_if.cfg_frame_len = '0;
        bus_if.cfg_inverse   = 1'b0;
        bus_if.vec_val       = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // ---- D=12, L=12, F=24: ready latency and first four sets ----
        do_start(12'd12, 12'd12, 16'd24, 1'b0);
        chk("ready_low_after_start", 64'(bus_if.ready), 64'(0));
        chk("demontr_latched", 64'(bus_if.twdl_demontr), 64'(12));
        // ready=1 from t+22 where t+1 is the cycle right after the start edge,
        // i.e. 21 edges after the start edge
        wait_ready(cyc);
        chk("ready_latency", 64'(cyc), 64'(21));
        chk("err_clear_run", 64'(bus_if.err), 64'(0));
        for (int i = 0; i < 4; i++) begin
            e = '{n: 12'(i), q: 20'(q12[i]), r: 12'(r12[i]), sop: (i == 0),
                  fd: 1'b0, inv: 1'b0, dmn: 12'd12};
            bus_if.vec_val = 1'b1;
            sb.push_back(e);
            @(negedge clk);
        end
        bus_if.vec_val = 1'b0;
        drain();
        chk("hold_quotient", 64'(bus_if.twdl_quotient), 64'(262144));
        chk("no_val_idle", 64'(bus_if.twdl_val), 64'(0));

        // ---- D=5, L=5, F=10: n wrap and frame wrap, full rate ----
        do_start(12'd5, 12'd5, 16'd10, 1'b0);
        wait_ready(cyc);
        for (int i = 0; i < 12; i++) begin
            e = '{n: 12'(i % 5), q: 20'(q5[i % 5]), r: 12'(r5[i % 5]),
                  sop: ((i % 10) == 0), fd: ((i % 10) == 9), inv: 1'b0, dmn: 12'd5};
            bus_if.vec_val = 1'b1;
            sb.push_back(e);
            @(negedge clk);
        end
        bus_if.vec_val = 1'b0;
        drain();

        // ---- D=1, L=1, F=3, inverse ----
        do_start(12'd1, 12'd1, 16'd3, 1'b1);
        chk("inverse_latched", 64'(bus_if.inverse), 64'(1));
        wait_ready(cyc);
        for (int i = 0; i < 7; i++) begin
            e = '{n: 12'd0, q: 20'd0, r: 12'd0, sop: ((i % 3) == 0),
                  fd: ((i % 3) == 2), inv: 1'b1, dmn: 12'd1};
            bus_if.vec_val = 1'b1;
            sb.push_back(e);
            @(negedge clk);
        end
        bus_if.vec_val = 1'b0;
        drain();

        // ---- vec_val during DIV ----
        do_start(12'd7, 12'd7, 16'd4, 1'b0);
        repeat (3) @(negedge clk);
        bus_if.vec_val = 1'b1;
        @(negedge clk);
        bus_if.vec_val = 1'b0;
        chk("err_vec_in_div", 64'(bus_if.err), 64'(1));
        chk("no_val_in_div", 64'(bus_if.twdl_val), 64'(0));
        @(negedge clk);
        chk("err_sticky", 64'(bus_if.err), 64'(1));
        do_start(12'd12, 12'd12, 16'd24, 1'b0);
        chk("err_cleared_by_start", 64'(bus_if.err), 64'(0));
        wait_ready(cyc);

        // ---- configuration errors ----
        do_start(12'd12, 12'd13, 16'd24, 1'b0);
        chk("err_l_gt_d", 64'(bus_if.err), 64'(1));
        repeat (25) @(negedge clk);
        chk("idle_after_l_gt_d", 64'(bus_if.ready), 64'(0));
        do_start(12'd12, 12'd12, 16'd24, 1'b0);
        chk("err_cleared_again", 64'(bus_if.err), 64'(0));
        do_start(12'd0, 12'd1, 16'd1, 1'b0);
        chk("err_d_zero", 64'(bus_if.err), 64'(1));
        repeat (25) @(negedge clk);
        chk("idle_after_d_zero", 64'(bus_if.ready), 64'(0));

        // ---- mid-RUN start, async reset during DIV, clean restart ----
        do_start(12'd12, 12'd12, 16'd24, 1'b0);
        wait_ready(cyc);
        for (int i = 0; i < 3; i++) begin
            e = '{n: 12'(i), q: 20'(q12[i]), r: 12'(r12[i]), sop: (i == 0),
                  fd: 1'b0, inv: 1'b0, dmn: 12'd12};
            bus_if.vec_val = 1'b1;
            sb.push_back(e);
            @(negedge clk);
        end
        bus_if.vec_val = 1'b0;
        drain();
        do_start(12'd3, 12'd3, 16'd2, 1'b1);
        chk("ready_low_mid_run_start", 64'(bus_if.ready), 64'(0));
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_start(12'd3, 12'd3, 16'd2, 1'b0);
        wait_ready(cyc);
        chk("ready_latency_after_reset", 64'(cyc), 64'(21));
        for (int i = 0; i < 4; i++) begin
            e = '{n: 12'(i % 3), q: 20'(q3[i % 3]), r: 12'(r3[i % 3]),
                  sop: ((i % 2) == 0), fd: ((i % 2) == 1), inv: 1'b0, dmn: 12'd3};
            bus_if.vec_val = 1'b1;
            sb.push_back(e);
            @(negedge clk);
        end
        bus_if.vec_val = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
